// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle for hazard_ctrl_unit: stage register ids/enables in, stall/flush/forward controls out.
// Perf counter outputs exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_AW = 5
`ifdef HAZ_PERF_CNT_EN
    , parameter int unsigned PERF_W = 32
`endif
);
    logic [REG_AW-1:0] RS1_D;
    logic [REG_AW-1:0] RS2_D;
    logic [REG_AW-1:0] RS1_E;
    logic [REG_AW-1:0] RS2_E;
    logic [REG_AW-1:0] RD_E;
    logic [REG_AW-1:0] RD_M;
    logic [REG_AW-1:0] RD_W;
    logic              RegWriteE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic [1:0]        ResultSrcE;
    logic              PCSrcE;
    logic              MemReqM;
    logic              MemReadyM;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushD;
    logic              FlushE;
    logic              FlushW;
    logic              MemErr;
`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] PerfLuStall;
    logic [PERF_W-1:0] PerfMemStall;
    logic [PERF_W-1:0] PerfBrFlush;
`endif

    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemErr
`ifdef HAZ_PERF_CNT_EN
        , input PerfLuStall, PerfMemStall, PerfBrFlush
`endif
    );

    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemErr
`ifdef HAZ_PERF_CNT_EN
        , output PerfLuStall, PerfMemStall, PerfBrFlush
`endif
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Unified hazard control: operand forwarding, load-use stall, branch flush and data-memory wait/timeout FSM.
// Optional saturating perf counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned PERF_W       = 32
) (
    input logic               clk,
    input logic               rst,
    hazard_ctrl_unit_if.slave hz
);
    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    if (WAIT_TIMEOUT < 2 || WAIT_TIMEOUT > 255) begin : g_bad_timeout
        $error("hazard_ctrl_unit: WAIT_TIMEOUT must be in 2..255");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("hazard_ctrl_unit: PERF_W must be at least 1");
    end

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_mem_err;
    logic             w_mem_stall;
    logic             w_timeout;
    logic             w_load_use;
    logic             w_branch;
    logic             w_unused_ok;

    // Youngest in-flight writer wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rd_m,
                                           input logic [REG_AW-1:0] rd_w,
                                           input logic              we_m,
                                           input logic              we_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Load destination is inferred from ResultSrcE, so the E-stage write enable is not consulted.
    assign w_unused_ok = hz.RegWriteE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_timeout;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = '0;
        w_mem_stall    = 1'b0;
        w_timeout      = 1'b0;
        w_load_use     = 1'b0;
        w_branch       = 1'b0;
        hz.ForwardAE   = 2'b00;
        hz.ForwardBE   = 2'b00;
        hz.StallF      = 1'b0;
        hz.StallD      = 1'b0;
        hz.StallE      = 1'b0;
        hz.StallM      = 1'b0;
        hz.FlushD      = 1'b0;
        hz.FlushE      = 1'b0;
        hz.FlushW      = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_mem_stall = hz.MemReqM && !hz.MemReadyM;
                if (w_mem_stall) begin
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                w_timeout      = !hz.MemReadyM && (r_wait_cnt == CNT_LAST);
                w_mem_stall    = !hz.MemReadyM && !w_timeout;
                if (hz.MemReadyM || w_timeout) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        w_load_use = (hz.ResultSrcE == 2'b01) && (hz.RD_E != '0) &&
                     ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));
        w_branch   = hz.PCSrcE;

        // Memory stall freezes everything and masks branch/load-use until the access is released.
        if (rst) begin
            hz.ForwardAE = fwd_sel(hz.RS1_E, hz.RD_M, hz.RD_W, hz.RegWriteM, hz.RegWriteW);
            hz.ForwardBE = fwd_sel(hz.RS2_E, hz.RD_M, hz.RD_W, hz.RegWriteM, hz.RegWriteW);
            if (w_mem_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else begin
                hz.FlushW = w_timeout;
                if (w_branch) begin
                    hz.FlushD = 1'b1;
                    hz.FlushE = 1'b1;
                end else if (w_load_use) begin
                    hz.StallF = 1'b1;
                    hz.StallD = 1'b1;
                    hz.FlushE = 1'b1;
                end
            end
        end
    end

    assign hz.MemErr = r_mem_err;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_lu;
    logic [PERF_W-1:0] r_perf_mem;
    logic [PERF_W-1:0] r_perf_br;

    // Each counter tracks cycles in which its hazard actually won output priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_lu  <= '0;
            r_perf_mem <= '0;
            r_perf_br  <= '0;
        end else begin
            if (!w_mem_stall && !w_branch && w_load_use && (r_perf_lu != '1)) begin
                r_perf_lu <= r_perf_lu + PERF_W'(1);
            end
            if (w_mem_stall && (r_perf_mem != '1)) begin
                r_perf_mem <= r_perf_mem + PERF_W'(1);
            end
            if (!w_mem_stall && w_branch && (r_perf_br != '1)) begin
                r_perf_br <= r_perf_br + PERF_W'(1);
            end
        end
    end

    assign hz.PerfLuStall  = r_perf_lu;
    assign hz.PerfMemStall = r_perf_mem;
    assign hz.PerfBrFlush  = r_perf_br;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_ctrl_unit;
    localparam int unsigned AW = 5;
    localparam int unsigned WT = 4;
    localparam int unsigned PW = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
    hazard_ctrl_unit_if #(.REG_AW(AW), .PERF_W(PW)) hz ();
`else
    hazard_ctrl_unit_if #(.REG_AW(AW)) hz ();
`endif

    hazard_ctrl_unit #(.REG_AW(AW), .WAIT_TIMEOUT(WT), .PERF_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // Reference model: "waiting" flag plus 1-based count of the current wait cycle.
    bit m_wait   = 1'b0;
    int m_waited = 0;
    bit m_err    = 1'b0;
    int m_perf_lu  = 0;
    int m_perf_mem = 0;
    int m_perf_br  = 0;

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
        if (hz.RegWriteM && hz.RD_M != 0 && hz.RD_M == rs) return 2'b10;
        if (hz.RegWriteW && hz.RD_W != 0 && hz.RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit mdl_timeout();
        return rst && m_wait && !hz.MemReadyM && (m_waited == WT);
    endfunction

    function automatic bit mdl_mem_stall();
        if (!rst) return 1'b0;
        if (m_wait) return !hz.MemReadyM && (m_waited < WT);
        return hz.MemReqM && !hz.MemReadyM;
    endfunction

    function automatic bit mdl_load_use();
        return hz.ResultSrcE == 2'b01 && hz.RD_E != 0 && (hz.RD_E == hz.RS1_D || hz.RD_E == hz.RS2_D);
    endfunction

    // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
    function automatic logic [12:0] exp_vec();
        bit ms, lu, br;
        ms = mdl_mem_stall();
        lu = mdl_load_use();
        br = hz.PCSrcE;
        if (!rst) return {12'b0, m_err};
        return {exp_fwd(hz.RS1_E), exp_fwd(hz.RS2_E), ms || (!br && lu), ms || (!br && lu), ms, ms,
                !ms && br, !ms && (br || lu), ms || mdl_timeout(), m_err};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW, hz.MemErr};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < (1 << PW) - 1) ? v + 1 : v;
    endfunction

    // Advance one clock and move the model along with it.
    task automatic tick();
        bit tout, ms, lu, br, req, rdy, rs;
        tout = mdl_timeout();
        ms   = mdl_mem_stall();
        lu   = mdl_load_use();
        br   = hz.PCSrcE;
        req  = hz.MemReqM;
        rdy  = hz.MemReadyM;
        rs   = rst;
        @(posedge clk);
        if (!rs) begin
            m_wait = 0; m_waited = 0; m_err = 0;
            m_perf_lu = 0; m_perf_mem = 0; m_perf_br = 0;
        end else begin
            m_err = tout;
            if (ms) m_perf_mem = sat_inc(m_perf_mem);
            if (!ms && br) m_perf_br = sat_inc(m_perf_br);
            if (!ms && !br && lu) m_perf_lu = sat_inc(m_perf_lu);
            if (!m_wait) begin
                if (req && !rdy) begin m_wait = 1; m_waited = 1; end
            end else if (rdy || tout) begin
                m_wait = 0; m_waited = 0;
            end else begin
                m_waited++;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        hz.RS1_D = '0; hz.RS2_D = '0; hz.RS1_E = '0; hz.RS2_E = '0;
        hz.RD_E = '0; hz.RD_M = '0; hz.RD_W = '0;
        hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.ResultSrcE = 2'b00; hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
    endtask

    task automatic rand_inputs(input bit mem_en);
        hz.RS1_D = AW'($urandom_range(3)); hz.RS2_D = AW'($urandom_range(3));
        hz.RS1_E = AW'($urandom_range(3)); hz.RS2_E = AW'($urandom_range(3));
        hz.RD_E  = AW'($urandom_range(3)); hz.RD_M  = AW'($urandom_range(3));
        hz.RD_W  = AW'($urandom_range(3));
        hz.RegWriteE = 1'($urandom_range(1));
        hz.RegWriteM = 1'($urandom_range(1));
        hz.RegWriteW = 1'($urandom_range(1));
        hz.ResultSrcE = 2'($urandom_range(3));
        hz.PCSrcE    = ($urandom_range(5) == 0);
        hz.MemReqM   = mem_en && ($urandom_range(2) == 0);
        hz.MemReadyM = ($urandom_range(2) == 0);
    endtask

    task automatic test_reset();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b1);
            hz.PCSrcE = 1; hz.MemReqM = 1; hz.MemReadyM = 0;
            tick();
            checks++;
            if (obs_vec() !== 13'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", i, obs_vec(), 13'b0);
            end
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if ({hz.PerfLuStall, hz.PerfMemStall, hz.PerfBrFlush} !== '0) begin
            errors++;
            $display("FAIL reset_perf got=%0d/%0d/%0d exp=0", hz.PerfLuStall, hz.PerfMemStall, hz.PerfBrFlush);
        end
`endif
        set_idle();
        rst = 1;
        #1;
    endtask

    task automatic test_forward();
        set_idle();
        hz.RegWriteM = 1; hz.RD_M = 5; hz.RS1_E = 5; hz.RegWriteW = 1; hz.RD_W = 5;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b10) begin
            errors++;
            $display("FAIL fwd_m_beats_w got=%b exp=10", hz.ForwardAE);
        end
        tick();
        hz.RegWriteM = 0; hz.RD_W = 9; hz.RS2_E = 9;
        #1;
        checks++;
        if (hz.ForwardBE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w_only got=%b exp=01", hz.ForwardBE);
        end
        tick();
        hz.RegWriteM = 1; hz.RD_M = 0; hz.RS1_E = 0; hz.RD_W = 0;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_x0 got=%b exp=00", hz.ForwardAE);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            rand_inputs(1'b0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fwd_rand cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_load_use();
        set_idle();
        hz.ResultSrcE = 2'b01; hz.RD_E = 7; hz.RS2_D = 7;
        #1;
        checks++;
        if ({hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushD} !== 5'b11100) begin
            errors++;
            $display("FAIL lu_stall got=%b exp=11100", {hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushD});
        end
        tick();
        hz.ResultSrcE = 2'b00;
        #1;
        checks++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
            errors++;
            $display("FAIL lu_one_cycle got=%b exp=000", {hz.StallF, hz.StallD, hz.FlushE});
        end
        tick();
        hz.ResultSrcE = 2'b01; hz.RD_E = 0; hz.RS1_D = 0; hz.RS2_D = 0;
        #1;
        checks++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
            errors++;
            $display("FAIL lu_x0 got=%b exp=000", {hz.StallF, hz.StallD, hz.FlushE});
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch();
        set_idle();
        hz.ResultSrcE = 2'b01; hz.RD_E = 3; hz.RS1_D = 3; hz.PCSrcE = 1;
        #1;
        checks++;
        if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallD} !== 4'b1100) begin
            errors++;
            $display("FAIL branch_over_lu got=%b exp=1100", {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD});
        end
        tick();
        set_idle();
    endtask

    task automatic test_mem_wait();
        set_idle();
        hz.MemReqM = 1; hz.MemReadyM = 0; hz.PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs_vec() !== 13'b0000_1111_0010) begin
                errors++;
                $display("FAIL mem_wait_stall cyc=%0d got=%b exp=%b", i, obs_vec(), 13'b0000_1111_0010);
            end
            tick();
        end
        hz.MemReadyM = 1; hz.PCSrcE = 0;
        #1;
        checks++;
        if (obs_vec() !== 13'b0) begin
            errors++;
            $display("FAIL mem_wait_release got=%b exp=%b", obs_vec(), 13'b0);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (hz.MemErr !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_no_err got=%b exp=0", hz.MemErr);
        end
        tick();
    endtask

    task automatic test_timeout();
        set_idle();
        hz.MemReqM = 1; hz.MemReadyM = 0;
        for (int i = 0; i < WT; i++) begin
            #1;
            checks++;
            if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.MemErr} !== 6'b111110) begin
                errors++;
                $display("FAIL timeout_stall cyc=%0d got=%b exp=111110", i,
                         {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.MemErr});
            end
            tick();
        end
        #1;
        checks++;
        if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW} !== 5'b00001) begin
            errors++;
            $display("FAIL timeout_drop got=%b exp=00001", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW});
        end
        tick();
        hz.MemReqM = 0;
        #1;
        checks++;
        if ({hz.MemErr, hz.StallF, hz.StallM, hz.FlushW} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_err got=%b exp=1000", {hz.MemErr, hz.StallF, hz.StallM, hz.FlushW});
        end
        tick();
        #1;
        checks++;
        if (hz.MemErr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width got=%b exp=0", hz.MemErr);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        set_idle();
        hz.MemReqM = 1; hz.MemReadyM = 0;
        tick();
        tick();
        rst = 0; hz.PCSrcE = 1; hz.RegWriteM = 1; hz.RD_M = 4; hz.RS1_E = 4;
        #1;
        checks++;
        if (obs_vec() !== 13'b0) begin
            errors++;
            $display("FAIL rst_mid_wait_outputs got=%b exp=%b", obs_vec(), 13'b0);
        end
        tick();
        rst = 1;
        set_idle();
        #1;
        checks++;
        if (obs_vec() !== 13'b0) begin
            errors++;
            $display("FAIL rst_mid_wait_after got=%b exp=%b", obs_vec(), 13'b0);
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if ({hz.PerfLuStall, hz.PerfMemStall, hz.PerfBrFlush} !== '0) begin
            errors++;
            $display("FAIL rst_mid_wait_perf got=%0d/%0d/%0d exp=0", hz.PerfLuStall, hz.PerfMemStall, hz.PerfBrFlush);
        end
`endif
        tick();
        hz.MemReqM = 1; hz.MemReadyM = 0;
        for (int i = 0; i < WT + 2; i++) begin
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid_wait_recount cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            rst = ($urandom_range(49) != 0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d rst=%b got=%b exp=%b", i, rst, obs_vec(), exp_vec());
            end
            tick();
        end
        rst = 1;
        set_idle();
        #1;
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (hz.PerfLuStall !== PW'(m_perf_lu) || hz.PerfMemStall !== PW'(m_perf_mem) ||
            hz.PerfBrFlush !== PW'(m_perf_br)) begin
            errors++;
            $display("FAIL random_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", hz.PerfLuStall, hz.PerfMemStall,
                     hz.PerfBrFlush, m_perf_lu, m_perf_mem, m_perf_br);
        end
`endif
    endtask

    initial begin
        set_idle();
        rst = 0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
